// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the writeback/debug requesters, the arbiter and the register file.
// The requesters drive the master side and the arbiter sits on the slave side.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              core_wr_req;
    logic [2:0]        core_dr;
    logic [DATA_W-1:0] core_data;
    logic              core_wr_ack;
    logic              dbg_wr_req;
    logic [2:0]        dbg_dr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_wr_ack;
    logic              clear_start;
    logic              clear_busy;
    logic              clear_done;
    logic              LD_REG;
    logic [2:0]        DR_OUT;
    logic [DATA_W-1:0] DATA_OUT;

    modport master (
        output core_wr_req, core_dr, core_data,
        input  core_wr_ack,
        output dbg_wr_req, dbg_dr, dbg_data,
        input  dbg_wr_ack,
        output clear_start,
        input  clear_busy, clear_done,
        input  LD_REG, DR_OUT, DATA_OUT
    );

    modport slave (
        input  core_wr_req, core_dr, core_data,
        output core_wr_ack,
        input  dbg_wr_req, dbg_dr, dbg_data,
        output dbg_wr_ack,
        input  clear_start,
        output clear_busy, clear_done,
        output LD_REG, DR_OUT, DATA_OUT
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the LC-3 register-file write port (core vs. debug),
// plus a clear sequence that writes CLEAR_VALUE to R0..R7. All port outputs are registered.
module regfile_write_arbiter #(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    regfile_write_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic              r_last, w_last_nxt;

    logic              r_ld, w_ld_nxt;
    logic [2:0]        r_dr, w_dr_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt;
    logic              r_core_ack, w_core_ack_nxt;
    logic              r_dbg_ack, w_dbg_ack_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    logic              w_core_elig, w_dbg_elig, w_arb_ok;
    logic              w_grant_core, w_grant_dbg;

    // A requester in its ack cycle is not eligible, so a held req is never granted twice back to back.
    assign w_core_elig  = bus.core_wr_req && !r_core_ack;
    assign w_dbg_elig   = bus.dbg_wr_req  && !r_dbg_ack;
    // DONE may arbitrate: the grant decided at its closing edge lands in the first IDLE cycle.
    assign w_arb_ok     = ((r_state == IDLE) && !bus.clear_start) || (r_state == DONE);
    assign w_grant_core = w_arb_ok && w_core_elig && (!w_dbg_elig || r_last);
    assign w_grant_dbg  = w_arb_ok && w_dbg_elig && !w_grant_core;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last     <= 1'b1;
            r_ld       <= 1'b0;
            r_dr       <= '0;
            r_data     <= '0;
            r_core_ack <= 1'b0;
            r_dbg_ack  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_ld       <= w_ld_nxt;
            r_dr       <= w_dr_nxt;
            r_data     <= w_data_nxt;
            r_core_ack <= w_core_ack_nxt;
            r_dbg_ack  <= w_dbg_ack_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.clear_start) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                w_cnt_nxt = r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are computed for the coming cycle, so they follow the next state rather than the current one.
    always_comb begin
        w_ld_nxt       = 1'b0;
        w_dr_nxt       = r_dr;
        w_data_nxt     = r_data;
        w_core_ack_nxt = 1'b0;
        w_dbg_ack_nxt  = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        w_last_nxt     = r_last;
        if (w_state_nxt == CLEAR) begin
            w_ld_nxt   = 1'b1;
            w_dr_nxt   = w_cnt_nxt;
            w_data_nxt = CLEAR_VALUE;
            w_busy_nxt = 1'b1;
        end else if (w_state_nxt == DONE) begin
            w_done_nxt = 1'b1;
        end else if (w_grant_core) begin
            w_ld_nxt       = 1'b1;
            w_dr_nxt       = bus.core_dr;
            w_data_nxt     = bus.core_data;
            w_core_ack_nxt = 1'b1;
            w_last_nxt     = 1'b0;
        end else if (w_grant_dbg) begin
            w_ld_nxt      = 1'b1;
            w_dr_nxt      = bus.dbg_dr;
            w_data_nxt    = bus.dbg_data;
            w_dbg_ack_nxt = 1'b1;
            w_last_nxt    = 1'b1;
        end
    end

    assign bus.LD_REG      = r_ld;
    assign bus.DR_OUT      = r_dr;
    assign bus.DATA_OUT    = r_data;
    assign bus.core_wr_ack = r_core_ack;
    assign bus.dbg_wr_ack  = r_dbg_ack;
    assign bus.clear_busy  = r_busy;
    assign bus.clear_done  = r_done;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: per-cycle vector table, clear-sequence
// corner cases, and a write scoreboard backed by a small register-file model.
module tb_regfile_write_arbiter;
    localparam logic [15:0] CLEAR_V = 16'h0000;

    logic Clk;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    regfile_write_arbiter_if #(.DATA_W(16)) bus ();

    regfile_write_arbiter #(.DATA_W(16), .CLEAR_VALUE(CLEAR_V)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [2:0]  dr;
        logic [15:0] data;
    } wr_t;
    wr_t sbq [$];

    logic [15:0] rf [8] = '{default: 16'hDEAD};

    typedef struct {
        logic        creq;
        logic [2:0]  cdr;
        logic [15:0] cdat;
        logic        dreq;
        logic [2:0]  ddr;
        logic [15:0] ddat;
        logic        ld;
        logic [2:0]  dr;
        logic [15:0] dat;
        logic        cack;
        logic        dack;
    } vec_t;
    vec_t vt [14];

    function automatic void check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", n, act, exp);
        end
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [2:0] dr, input logic [15:0] data);
        wr_t w;
        w.dr   = dr;
        w.data = data;
        sbq.push_back(w);
    endtask

    task automatic check_out(input string n, input logic ld, input logic [2:0] dr, input logic [15:0] d,
                             input logic ca, input logic da, input logic busy, input logic done);
        check({n, "_ld"},   32'(bus.LD_REG),      32'(ld));
        check({n, "_dr"},   32'(bus.DR_OUT),      32'(dr));
        check({n, "_data"}, 32'(bus.DATA_OUT),    32'(d));
        check({n, "_cack"}, 32'(bus.core_wr_ack), 32'(ca));
        check({n, "_dack"}, 32'(bus.dbg_wr_ack),  32'(da));
        check({n, "_busy"}, 32'(bus.clear_busy),  32'(busy));
        check({n, "_done"}, 32'(bus.clear_done),  32'(done));
    endtask

    // Register-file model: captures whatever the port presents when LD_REG is high.
    always @(posedge Clk) begin
        if (bus.LD_REG === 1'b1) rf[bus.DR_OUT] <= bus.DATA_OUT;
    end

    // Scoreboard: every write on the port must match the next expected write, in order.
    always @(negedge Clk) begin
        if (bus.LD_REG === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got write dr=%0d data=%h, required no write", bus.DR_OUT, bus.DATA_OUT);
            end else begin
                wr_t e;
                e = sbq.pop_front();
                check("sb_dr",   32'(bus.DR_OUT),   32'(e.dr));
                check("sb_data", 32'(bus.DATA_OUT), 32'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of test");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1234, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd3, 16'h1234, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'h0F0F, 1'b1, 3'd6, 16'h0F0F, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd6, 16'h0F0F, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b1, 3'd1, 16'hAAAA, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b1, 3'd2, 16'h5555, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b1, 3'd1, 16'hAAAA, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 1'b1, 3'd2, 16'h5555, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 3'd1, 16'hAAAA, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 16'hAAAA, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 16'hAAAA, 1'b0, 1'b0};
        vt[10] = '{1'b1, 3'd7, 16'hFFFF, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0};
        vt[11] = '{1'b1, 3'd0, 16'h2222, 1'b1, 3'd4, 16'h1111, 1'b1, 3'd4, 16'h1111, 1'b0, 1'b1};
        vt[12] = '{1'b1, 3'd0, 16'h2222, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 16'h2222, 1'b1, 1'b0};
        vt[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h2222, 1'b0, 1'b0};

        Reset           = 1'b1;
        bus.core_wr_req = 1'b0;
        bus.core_dr     = '0;
        bus.core_data   = '0;
        bus.dbg_wr_req  = 1'b0;
        bus.dbg_dr      = '0;
        bus.dbg_data    = '0;
        bus.clear_start = 1'b0;
        tick;
        tick;
        check_out("reset", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;

        // Single grants, round-robin alternation and the held-req-during-ack case.
        for (int i = 0; i < 14; i++) begin
            bus.core_wr_req = vt[i].creq;
            bus.core_dr     = vt[i].cdr;
            bus.core_data   = vt[i].cdat;
            bus.dbg_wr_req  = vt[i].dreq;
            bus.dbg_dr      = vt[i].ddr;
            bus.dbg_data    = vt[i].ddat;
            if (vt[i].ld) push(vt[i].dr, vt[i].dat);
            tick;
            check_out($sformatf("vec%0d", i), vt[i].ld, vt[i].dr, vt[i].dat, vt[i].cack, vt[i].dack, 1'b0, 1'b0);
        end

        // Clear with a debug request arriving mid-sequence.
        bus.clear_start = 1'b1;
        for (int i = 0; i < 8; i++) push(3'(i), CLEAR_V);
        tick;
        bus.clear_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_out($sformatf("clrA_c%0d", i + 1), 1'b1, 3'(i), CLEAR_V, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 1) begin
                bus.dbg_wr_req = 1'b1;
                bus.dbg_dr     = 3'd5;
                bus.dbg_data   = 16'hBEEF;
                push(3'd5, 16'hBEEF);
            end
            tick;
        end
        check_out("clrA_done", 1'b0, 3'd7, CLEAR_V, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) check($sformatf("rfA_r%0d", i), 32'(rf[i]), 32'(CLEAR_V));
        tick;
        check_out("clrA_dbg", 1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.dbg_wr_req = 1'b0;
        tick;
        check_out("clrA_idle", 1'b0, 3'd5, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);

        // clear_start and core request at the same edge; a second clear_start mid-sequence is ignored.
        bus.clear_start = 1'b1;
        bus.core_wr_req = 1'b1;
        bus.core_dr     = 3'd3;
        bus.core_data   = 16'hC0DE;
        for (int i = 0; i < 8; i++) push(3'(i), CLEAR_V);
        push(3'd3, 16'hC0DE);
        tick;
        for (int i = 0; i < 8; i++) begin
            check_out($sformatf("clrB_c%0d", i + 1), 1'b1, 3'(i), CLEAR_V, 1'b0, 1'b0, 1'b1, 1'b0);
            bus.clear_start = (i == 2);
            tick;
        end
        bus.clear_start = 1'b0;
        check_out("clrB_done", 1'b0, 3'd7, CLEAR_V, 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        check_out("clrB_core", 1'b1, 3'd3, 16'hC0DE, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.core_wr_req = 1'b0;
        tick;
        check_out("clrB_idle", 1'b0, 3'd3, 16'hC0DE, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        check_out("clrB_idle2", 1'b0, 3'd3, 16'hC0DE, 1'b0, 1'b0, 1'b0, 1'b0);

        // Fill R0..R7 with distinct values, then reset partway through a clear.
        for (int i = 0; i < 8; i++) begin
            bus.core_wr_req = 1'b1;
            bus.core_dr     = 3'(i);
            bus.core_data   = 16'h5A00 + 16'(i);
            push(3'(i), 16'h5A00 + 16'(i));
            tick;
            check_out($sformatf("fill%0d", i), 1'b1, 3'(i), 16'h5A00 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            bus.core_wr_req = 1'b0;
            tick;
        end
        bus.clear_start = 1'b1;
        for (int i = 0; i < 3; i++) push(3'(i), CLEAR_V);
        tick;
        bus.clear_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_out($sformatf("clrC_c%0d", i + 1), 1'b1, 3'(i), CLEAR_V, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i == 2) Reset = 1'b1;
            tick;
        end
        check_out("rstC", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            check($sformatf("rfC_r%0d", i), 32'(rf[i]), (i < 3) ? 32'(CLEAR_V) : 32'(16'h5A00 + 16'(i)));
        Reset = 1'b0;

        // After reset the pointer favours the core again and the clear does not resume.
        bus.core_wr_req = 1'b1;
        bus.core_dr     = 3'd1;
        bus.core_data   = 16'h1111;
        bus.dbg_wr_req  = 1'b1;
        bus.dbg_dr      = 3'd2;
        bus.dbg_data    = 16'h2222;
        push(3'd1, 16'h1111);
        push(3'd2, 16'h2222);
        tick;
        check_out("postC_core", 1'b1, 3'd1, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.core_wr_req = 1'b0;
        tick;
        check_out("postC_dbg", 1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.dbg_wr_req = 1'b0;
        tick;
        check_out("postC_idle", 1'b0, 3'd2, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;

        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
